// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: fetch FSM encoding, the reset NOP and
// the base opcode constants also consumed by the ALU control decoder.
package riscv_pkg;

    typedef enum logic [1:0] {
        FS_REQ  = 2'd0,
        FS_WAIT = 2'd1,
        FS_HOLD = 2'd2,
        FS_DROP = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

endpackage

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, keeps at most one instruction-memory request in
// flight, applies execute-stage redirects and hands one word at a time to decode.
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter int          XLEN      = 32,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] RESET_NOP = NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_instr,
    output logic [6:0]      opcode,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic            misalign_err
);

    fetch_state_e    state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] out_pc_q;
    logic [31:0]     out_instr_q;
    logic            misalign_q;
    logic [XLEN-1:0] redir_tgt;

    assign redir_tgt = {redirect_pc[XLEN-1:2], 2'b00};

    // A same-cycle redirect suppresses both handshakes so nothing stale escapes.
    assign imem_req_valid = (state_q == FS_REQ)  && !redirect_valid;
    assign out_valid      = (state_q == FS_HOLD) && !redirect_valid;
    assign imem_req_addr  = pc_q;
    assign out_pc         = out_pc_q;
    assign out_instr      = out_instr_q;
    assign opcode         = out_instr_q[6:0];
    assign funct3         = out_instr_q[14:12];
    assign funct7         = out_instr_q[31:25];
    assign misalign_err   = misalign_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FS_REQ;
            pc_q        <= RESET_PC[XLEN-1:0];
            out_pc_q    <= '0;
            out_instr_q <= RESET_NOP;
            misalign_q  <= 1'b0;
        end else begin
            misalign_q <= redirect_valid && (redirect_pc[1:0] != 2'b00);
            case (state_q)
                FS_REQ: begin
                    if (redirect_valid)      pc_q    <= redir_tgt;
                    else if (imem_req_ready) state_q <= FS_WAIT;
                end
                FS_WAIT: begin
                    if (redirect_valid) begin
                        pc_q    <= redir_tgt;
                        state_q <= imem_rsp_valid ? FS_REQ : FS_DROP;
                    end else if (imem_rsp_valid) begin
                        out_instr_q <= imem_rsp_data;
                        out_pc_q    <= pc_q;
                        pc_q        <= pc_q + XLEN'(4);
                        state_q     <= FS_HOLD;
                    end
                end
                FS_HOLD: begin
                    if (redirect_valid) begin
                        pc_q    <= redir_tgt;
                        state_q <= FS_REQ;
                    end else if (out_ready) begin
                        state_q <= FS_REQ;
                    end
                end
                FS_DROP: begin
                    // The in-flight word belongs to the squashed path; a response
                    // arriving alongside a fresh redirect still retires it.
                    if (redirect_valid) pc_q    <= redir_tgt;
                    if (imem_rsp_valid) state_q <= FS_REQ;
                end
                default: state_q <= FS_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus a random phase, all
// checked against a stream-level model (expected PC, memory image, one-in-flight).
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid, out_ready;
    logic [31:0] out_pc, out_instr;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic        misalign_err;

    int checks = 0;
    int errors = 0;

    instr_fetch_unit dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr),
        .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    // Memory image: three fixed words at 0/4/8, a hash elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0: return 32'h0050_0093;
            32'h4: return 32'h0020_8133;
            32'h8: return 32'h0020_F1B3;
            default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory model state
    logic        pend = 1'b0;
    int          pend_cnt = 0;
    logic [31:0] pend_addr = '0;
    int          lat_extra = 0;

    // Reference model state
    logic [31:0] exp_pc = '0;
    logic        exp_mis = 1'b0;

    // Per-step observations
    logic        acc_f, del_f, ov_f, rqv_f, mis_f;
    logic [31:0] acc_addr, del_pc, del_instr;
    logic [6:0]  del_op;
    logic [2:0]  del_f3;
    int          cyc = 0;

    task automatic step();
        logic [31:0] tgt;
        imem_rsp_valid = pend && (pend_cnt == 0);
        imem_rsp_data  = imem_rsp_valid ? mem_word(pend_addr) : $urandom;
        #1;
        acc_f = imem_req_valid && imem_req_ready;
        del_f = out_valid && out_ready;
        ov_f  = out_valid;
        rqv_f = imem_req_valid;
        mis_f = misalign_err;
        acc_addr = imem_req_addr;
        del_pc = out_pc; del_instr = out_instr; del_op = opcode; del_f3 = funct3;
        if (!rst) begin
            chk("misalign_err", {31'b0, misalign_err}, {31'b0, exp_mis});
            if (imem_req_valid) begin
                chk("single_outstanding", {31'b0, pend}, 32'd0);
                chk("req_addr", imem_req_addr, exp_pc);
            end
            if (redirect_valid) chk("out_valid_under_redirect", {31'b0, out_valid}, 32'd0);
            if (out_valid) begin
                chk("out_pc", out_pc, exp_pc);
                chk("out_instr", out_instr, mem_word(exp_pc));
                chk("opcode", {25'b0, opcode}, {25'b0, mem_word(exp_pc) & 32'h7F});
                chk("funct3", {29'b0, funct3}, (mem_word(exp_pc) >> 12) & 32'h7);
                chk("funct7", {25'b0, funct7}, mem_word(exp_pc) >> 25);
            end
        end
        tgt = redirect_pc & 32'hFFFF_FFFC;
        @(posedge clk);
        if (rst) begin
            pend = 1'b0; exp_pc = '0; exp_mis = 1'b0;
        end else begin
            if (imem_rsp_valid) pend = 1'b0;
            else if (pend) pend_cnt--;
            if (acc_f) begin pend = 1'b1; pend_cnt = lat_extra; pend_addr = acc_addr; end
            if (redirect_valid) exp_pc = tgt;
            else if (del_f) exp_pc = exp_pc + 32'd4;
            exp_mis = redirect_valid && (redirect_pc[1:0] != 2'b00);
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_until_acc(input string tag, output logic [31:0] addr);
        logic got = 1'b0;
        addr = 'x;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            if (acc_f) begin got = 1'b1; addr = acc_addr; end
        end
        chk({tag, "_acc_timeout"}, {31'b0, got}, 32'd1);
    endtask

    task automatic run_until_del(input string tag, output logic [31:0] pc, output int at);
        logic got = 1'b0;
        pc = 'x; at = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            if (del_f) begin got = 1'b1; pc = del_pc; at = cyc; end
        end
        chk({tag, "_del_timeout"}, {31'b0, got}, 32'd1);
    endtask

    task automatic run_until_ov(input string tag);
        logic got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            if (ov_f) got = 1'b1;
        end
        chk({tag, "_ov_timeout"}, {31'b0, got}, 32'd1);
    endtask

    initial begin
        logic [31:0] a, p, hold_pc, hold_instr;
        int          t0, t1, t2, ndel;
        logic [6:0]  ops [3];
        logic [2:0]  f3s [3];
        logic [31:0] pcs [3];

        rst = 1'b1; imem_req_ready = 1'b1; out_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = '0;
        imem_rsp_valid = 1'b0; imem_rsp_data = '0;

        // Reset
        step(); step();
        rst = 1'b0; #1;
        chk("rst_req_addr", imem_req_addr, 32'h0);
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_instr", out_instr, 32'h0000_0013);
        chk("rst_misalign", {31'b0, misalign_err}, 32'd0);

        // Zero-wait memory, decode always ready: addresses 0/4/8, one per 3 cycles
        lat_extra = 0;
        for (int k = 0; k < 3; k++) begin
            run_until_acc("seq", a);
            chk("seq_req_addr", a, 32'(k * 4));
            run_until_del("seq", pcs[k], t2);
            ops[k] = del_op; f3s[k] = del_f3;
            if (k == 0) t0 = t2;
            if (k == 2) t1 = t2;
        end
        chk("seq_pc0", pcs[0], 32'h0);
        chk("seq_pc1", pcs[1], 32'h4);
        chk("seq_pc2", pcs[2], 32'h8);
        chk("seq_op0", {25'b0, ops[0]}, 32'b0010011);
        chk("seq_op1", {25'b0, ops[1]}, 32'b0110011);
        chk("seq_op2", {25'b0, ops[2]}, 32'b0110011);
        chk("seq_f3_0", {29'b0, f3s[0]}, 32'd0);
        chk("seq_f3_2", {29'b0, f3s[2]}, 32'd7);
        chk("seq_throughput", 32'(t1 - t0), 32'd6);

        // Decode stalls for 5 cycles: output held, no new request
        out_ready = 1'b0;
        run_until_ov("hold");
        hold_pc = del_pc; hold_instr = del_instr;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("hold_out_valid", {31'b0, ov_f}, 32'd1);
            chk("hold_no_req", {31'b0, rqv_f}, 32'd0);
            chk("hold_pc", del_pc, hold_pc);
            chk("hold_instr", del_instr, hold_instr);
        end
        out_ready = 1'b1;
        step();
        chk("hold_release", {31'b0, del_f}, 32'd1);

        // Redirect while waiting; stale response arrives 2 cycles later
        lat_extra = 2;
        run_until_acc("wredir", a);
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        step();
        redirect_valid = 1'b0;
        lat_extra = 0;
        run_until_acc("wredir", a);
        chk("wredir_req_addr", a, 32'h100);
        run_until_del("wredir", p, t2);
        chk("wredir_out_pc", p, 32'h100);

        // Misaligned redirect coinciding with the response
        run_until_acc("mis", a);
        redirect_valid = 1'b1; redirect_pc = 32'h202;
        step();
        redirect_valid = 1'b0;
        step();
        chk("mis_pulse", {31'b0, mis_f}, 32'd1);
        chk("mis_req_valid", {31'b0, acc_f}, 32'd1);
        chk("mis_req_addr", acc_addr, 32'h200);
        step();
        chk("mis_pulse_end", {31'b0, mis_f}, 32'd0);

        // PC wrap at the top of the address space
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        run_until_del("wrap", p, t2);
        chk("wrap_out_pc", p, 32'hFFFF_FFFC);
        run_until_acc("wrap", a);
        chk("wrap_req_addr", a, 32'h0);

        // Reset while holding an instruction
        out_ready = 1'b0;
        run_until_ov("rsthold");
        rst = 1'b1;
        step();
        rst = 1'b0; #1;
        chk("rsthold_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rsthold_req_addr", imem_req_addr, 32'h0);
        chk("rsthold_out_instr", out_instr, 32'h0000_0013);
        out_ready = 1'b1;

        // Random traffic against the stream model
        ndel = 0;
        for (int k = 0; k < 3000; k++) begin
            rst            = ($urandom_range(0, 299) == 0);
            imem_req_ready = ($urandom_range(0, 3) != 0);
            out_ready      = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_pc    = $urandom;
            if ($urandom_range(0, 1) == 0) redirect_pc[1:0] = 2'b00;
            lat_extra      = $urandom_range(0, 3);
            step();
            if (del_f && !rst) ndel++;
        end
        rst = 1'b0; redirect_valid = 1'b0;
        chk("rand_progress", {31'b0, (ndel > 150)}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
